// File: rtl/key_debounce_array.sv
// N-channel push-button front end: two-flop synchroniser, debounce, press/release
// edge pulses, and per-channel long-press detection with optional auto-repeat.
module key_debounce_array #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int LONG_CYCLES     = 1_000_000,
   parameter int REPEAT_CYCLES   = 200_000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_KEYS-1:0] i_keys,
   input  logic [N_KEYS-1:0] i_repeat_en,
   output logic [N_KEYS-1:0] o_level,
   output logic [N_KEYS-1:0] o_press,
   output logic [N_KEYS-1:0] o_release,
   output logic [N_KEYS-1:0] o_long,
   output logic [N_KEYS-1:0] o_repeat
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   // A released pin reads high for active-low keys, low otherwise.
   localparam logic [N_KEYS-1:0] RELEASED_RAW = {N_KEYS{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_LONG
   } hold_state_t;

   logic [N_KEYS-1:0] sync_meta;
   logic [N_KEYS-1:0] sync_q;
   logic [N_KEYS-1:0] pressed;

   // NOTE: every register in this file uses non-blocking assignment so all
   // channels sample the pre-edge values of each other's state consistently.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_meta <= RELEASED_RAW;
         sync_q    <= RELEASED_RAW;
      end else begin
         sync_meta <= i_keys;
         sync_q    <= sync_meta;
      end
   end

   assign pressed = ACTIVE_LOW ? ~sync_q : sync_q;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
      logic [DB_W-1:0]   db_cnt;
      logic [HOLD_W-1:0] hold_cnt;
      logic [REP_W-1:0]  rep_cnt;
      hold_state_t       state;
      logic              level_q;
      logic              press_q;
      logic              release_q;
      logic              long_q;
      logic              repeat_q;
      logic              differs;
      logic              flip;
      logic              rise;
      logic              fall;

      assign differs = (pressed[k] != level_q);
      assign flip    = differs && (db_cnt == DB_LAST);
      assign rise    = flip && !level_q;
      assign fall    = flip && level_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            state     <= ST_IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            if (!differs || flip) begin
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end

            if (flip) begin
               level_q <= ~level_q;
            end
            press_q   <= rise;
            release_q <= fall;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;

            // Hold count saturates at LONG_CYCLES so a very long hold never re-arms o_long.
            if (!level_q || fall) begin
               hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_cnt <= hold_cnt + 1'b1;
            end

            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     state <= ST_HELD;
                  end
               end
               ST_HELD: begin
                  if (fall) begin
                     state <= ST_IDLE;
                  end else if (hold_cnt == HOLD_LAST) begin
                     state  <= ST_LONG;
                     long_q <= 1'b1;
                  end
               end
               ST_LONG: begin
                  if (fall) begin
                     state   <= ST_IDLE;
                     rep_cnt <= '0;
                  end else if (!i_repeat_en[k]) begin
                     rep_cnt <= '0;
                  end else if (rep_cnt == REP_LAST) begin
                     rep_cnt  <= '0;
                     repeat_q <= 1'b1;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  rep_cnt <= '0;
               end
            endcase
         end
      end

      assign o_level[k]   = level_q;
      assign o_press[k]   = press_q;
      assign o_release[k] = release_q;
      assign o_long[k]    = long_q;
      assign o_repeat[k]  = repeat_q;
   end

endmodule
